// File: rtl/apb_arb_master.sv
// apb_arb_master: two-requester arbiter in front of a single APB master port.
// The slave is zero-wait, so every transfer runs IDLE -> SETUP -> ACCESS -> RESP.
// A request sampled in IDLE at cycle T reaches SETUP at T+1, ACCESS at T+2 and
// RESP (req_done pulse) at T+3. Transfers can therefore follow each other every
// four cycles.
// The winning requester's direction, address and write data are latched when it
// is granted. Later changes on req_* do not affect the transfer in flight.
// Optional feature macro: APB_ARB_FIXED_PRIO_EN.
//   - Undefined (default): round-robin arbitration. A last-grant register resets
//     to 1, so requester 0 wins the first contention.
//   - Defined: fixed priority. Requester 0 always wins, and there is no
//     last-grant register.
// All outputs are registered. They are cleared asynchronously by PRESETn.
module apb_arb_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_done,
  output logic [DATA_W-1:0]     req_rdata,
  output logic                  gnt_id,
  output logic                  busy,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_W-1:0]     PADDR,
  output logic [DATA_W-1:0]     PWDATA,
  input  logic [DATA_W-1:0]     PRDATA
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                busy_q, busy_d;
  logic [1:0]          done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                grant_s;
`ifndef APB_ARB_FIXED_PRIO_EN
  logic                last_q, last_d;
`endif

  // Arbitration: choose which valid requester would win a grant this cycle
  always_comb begin
    grant_s = 1'b0;
`ifdef APB_ARB_FIXED_PRIO_EN
    if (req_valid[0]) begin
      grant_s = 1'b0;
    end else begin
      grant_s = 1'b1;
    end
`else
    if (req_valid == 2'b11) begin
      grant_s = ~last_q;
    end else if (req_valid[1]) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
`endif
  end

  // Next-state logic: transfer sequencing, payload latching and registered outputs
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
`ifndef APB_ARB_FIXED_PRIO_EN
    last_d   = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          state_d  = ST_SETUP;
          gnt_d    = grant_s;
          pwrite_d = req_write[grant_s];
          if (grant_s) begin
            paddr_d  = req_addr[2*ADDR_W-1:ADDR_W];
            pwdata_d = req_wdata[2*DATA_W-1:DATA_W];
          end else begin
            paddr_d  = req_addr[ADDR_W-1:0];
            pwdata_d = req_wdata[DATA_W-1:0];
          end
`ifndef APB_ARB_FIXED_PRIO_EN
          last_d   = grant_s;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are computed from the upcoming state so they register in step with it
    psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d = (state_d == ST_ACCESS);
    busy_d    = (state_d != ST_IDLE);
    if (state_d == ST_RESP) begin
      done_d = gnt_q ? 2'b10 : 2'b01;
      // Read data is captured at the end of ACCESS, the APB sample point
      if (!pwrite_q) begin
        rdata_d = PRDATA;
      end else begin
        rdata_d = {DATA_W{1'b0}};
      end
    end else begin
      done_d  = 2'b00;
      rdata_d = {DATA_W{1'b0}};
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= {ADDR_W{1'b0}};
      pwdata_q  <= {DATA_W{1'b0}};
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 2'b00;
      rdata_q   <= {DATA_W{1'b0}};
`ifndef APB_ARB_FIXED_PRIO_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
`ifndef APB_ARB_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  assign req_done  = done_q;
  assign req_rdata = rdata_q;
  assign gnt_id    = gnt_q;
  assign busy      = busy_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed self-checking bench for apb_arb_master with a zero-wait APB memory slave.
module tb_apb_arb_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            PCLK = 1'b0;
  logic            PRESETn;
  logic [1:0]      req_valid;
  logic [1:0]      req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      req_done;
  logic [DW-1:0]   req_rdata;
  logic            gnt_id;
  logic            busy;
  logic            PSEL;
  logic            PENABLE;
  logic            PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA;
  logic [DW-1:0]   PRDATA;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mem [0:15];

  apb_arb_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_rdata(req_rdata),
    .gnt_id(gnt_id), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  // Zero-wait slave: write in ACCESS, read data combinational from address
  always @(posedge PCLK) begin
    if (PSEL && PENABLE && PWRITE) mem[PADDR[5:2]] <= PWDATA;
  end
  assign PRDATA = mem[PADDR[5:2]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Runs SETUP, ACCESS and RESP of one transfer; returns while in RESP
  task automatic xfer(input logic eg, input logic [DW-1:0] er, input logic [AW-1:0] ea);
    tick();
    chk("setup_sel_en", {62'd0, PSEL, PENABLE}, 64'd2);
    chk("setup_gnt", {63'd0, gnt_id}, {63'd0, eg});
    chk("setup_paddr", {32'd0, PADDR}, {32'd0, ea});
    chk("setup_done", {62'd0, req_done}, 64'd0);
    chk("setup_busy", {63'd0, busy}, 64'd1);
    tick();
    chk("access_sel_en", {62'd0, PSEL, PENABLE}, 64'd3);
    chk("access_paddr", {32'd0, PADDR}, {32'd0, ea});
    chk("access_done", {62'd0, req_done}, 64'd0);
    tick();
    chk("resp_sel_en", {62'd0, PSEL, PENABLE}, 64'd0);
    chk("resp_done", {62'd0, req_done}, eg ? 64'd2 : 64'd1);
    chk("resp_rdata", {32'd0, req_rdata}, {32'd0, er});
    chk("resp_busy", {63'd0, busy}, 64'd1);
  endtask

  task automatic idle_chk();
    tick();
    chk("idle_psel", {63'd0, PSEL}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_done", {62'd0, req_done}, 64'd0);
  endtask

  initial begin
    logic          exp_gnt [0:5];
    logic [DW-1:0] exp_rd  [0:5];
    logic [AW-1:0] exp_ad  [0:5];

`ifdef APB_ARB_FIXED_PRIO_EN
    exp_gnt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_rd  = '{32'h0, 32'h0, 32'h0, 32'h11, 32'h11, 32'h11};
    exp_ad  = '{32'h04, 32'h04, 32'h04, 32'h04, 32'h04, 32'h04};
`else
    exp_gnt = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_rd  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h11, 32'h22};
    exp_ad  = '{32'h04, 32'h0C, 32'h04, 32'h0C, 32'h04, 32'h0C};
`endif

    // Reset state
    PRESETn   = 1'b0;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    tick();
    tick();
    chk("rst_sel_en", {62'd0, PSEL, PENABLE}, 64'd0);
    chk("rst_pwrite", {63'd0, PWRITE}, 64'd0);
    chk("rst_paddr", {32'd0, PADDR}, 64'd0);
    chk("rst_pwdata", {32'd0, PWDATA}, 64'd0);
    chk("rst_done", {62'd0, req_done}, 64'd0);
    chk("rst_rdata", {32'd0, req_rdata}, 64'd0);
    chk("rst_gnt_busy", {62'd0, gnt_id, busy}, 64'd0);
    PRESETn = 1'b1;
    tick();

    // Write then read on requester 0
    req_valid = 2'b01;
    req_write = 2'b01;
    req_addr  = {32'h0, 32'h08};
    req_wdata = {32'h0, 32'hDEADBEEF};
    xfer(1'b0, 32'h0, 32'h08);
    chk("wr_pwrite", {63'd0, PWRITE}, 64'd1);
    chk("wr_pwdata", {32'd0, PWDATA}, {32'd0, 32'hDEADBEEF});
    req_write = 2'b00;
    idle_chk();
    xfer(1'b0, 32'hDEADBEEF, 32'h08);
    req_valid = 2'b00;
    idle_chk();

    // Contention from reset: both requesters continuously valid
    PRESETn   = 1'b0;
    req_valid = 2'b11;
    req_write = 2'b11;
    req_addr  = {32'h0C, 32'h04};
    req_wdata = {32'h22, 32'h11};
    tick();
    PRESETn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      xfer(exp_gnt[k], exp_rd[k], exp_ad[k]);
      if (k == 2) req_write[0] = 1'b0;
      if (k == 3) req_write[1] = 1'b0;
      if (k == 5) req_valid = 2'b00;
      tick();
      chk("c_idle_busy", {63'd0, busy}, 64'd0);
    end

    // Payload change after grant does not reach the bus
    req_valid = 2'b01;
    req_write = 2'b01;
    req_addr  = {32'h0, 32'h10};
    req_wdata = {32'h0, 32'h33};
    tick();
    chk("pl_setup_paddr", {32'd0, PADDR}, 64'h10);
    req_addr  = {32'h0, 32'h20};
    req_wdata = {32'h0, 32'h44};
    tick();
    chk("pl_access_paddr", {32'd0, PADDR}, 64'h10);
    chk("pl_access_pwdata", {32'd0, PWDATA}, 64'h33);
    chk("pl_access_en", {62'd0, PSEL, PENABLE}, 64'd3);
    tick();
    chk("pl_resp_done", {62'd0, req_done}, 64'd1);
    req_valid = 2'b00;
    tick();

    // Reset during ACCESS aborts the transfer
    req_valid = 2'b01;
    req_write = 2'b01;
    req_addr  = {32'h0, 32'h14};
    req_wdata = {32'h0, 32'h55};
    tick();
    tick();
    chk("mr_access", {62'd0, PSEL, PENABLE}, 64'd3);
    #1;
    PRESETn = 1'b0;
    #1;
    chk("mr_sel_en", {62'd0, PSEL, PENABLE}, 64'd0);
    chk("mr_pwrite", {63'd0, PWRITE}, 64'd0);
    chk("mr_paddr", {32'd0, PADDR}, 64'd0);
    chk("mr_pwdata", {32'd0, PWDATA}, 64'd0);
    chk("mr_done", {62'd0, req_done}, 64'd0);
    chk("mr_gnt_busy", {62'd0, gnt_id, busy}, 64'd0);
    req_valid = 2'b00;
    tick();
    chk("mr_done_hold", {62'd0, req_done}, 64'd0);
    PRESETn   = 1'b1;
    req_valid = 2'b10;
    req_write = 2'b10;
    req_addr  = {32'h18, 32'h0};
    req_wdata = {32'h66, 32'h0};
    xfer(1'b1, 32'h0, 32'h18);
    req_valid = 2'b00;
    tick();

    // Idle for ten cycles
    for (int i = 0; i < 10; i++) begin
      idle_chk();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
